// File: rtl/line_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module   : line_pixel_writer
//  Brief    : Buffers Bresenham pixel addresses in a small FIFO, converts
//             {y,x} to a linear frame-buffer address and commits each pixel
//             to SRAM through a single-beat we/ack handshake. Drives stop as
//             backpressure and pulses write_done once a line is committed.
//  Options  : LINE_PIXEL_WRITER_DUPFILT_EN - drop a pushed address equal to
//             the previously accepted address of the same line.
//  Revision : 1.0 - initial release
// ============================================================================
module line_pixel_writer #(
    parameter int DEPTH   = 8,
    parameter int COLOR_W = 8,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [18:0]        address,
    input  logic               line_done,
    input  logic [COLOR_W-1:0] color,
    output logic               stop,
    output logic               mem_we,
    output logic [18:0]        mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic               mem_ack,
    output logic               write_done,
    output logic               busy
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_STOP_LVL = (c_AW + 1)'(DEPTH - 2);
    localparam logic [18:0]     c_HRES19   = 19'(H_RES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [18:0]        r_fifo [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic [c_AW:0]      w_count_nxt;
    logic [COLOR_W-1:0] r_color;
    logic               r_stop;

    logic [9:0]         w_x;
    logic [8:0]         w_y;
    logic [18:0]        w_lin;
    logic               w_in_range;
    logic               w_accept_state;
    logic               w_dup;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    assign w_x   = address[9:0];
    assign w_y   = address[18:10];
    // Linear address is formed before the FIFO so the write stage only has to
    // present stored words.
    assign w_lin = ({10'd0, w_y} * c_HRES19) + {9'd0, w_x};

    assign w_in_range     = ({22'd0, w_x} < H_RES) && ({23'd0, w_y} < V_RES);
    assign w_accept_state = (r_state == c_IDLE) || (r_state == c_RUN);
    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_FULL);

    // A push while full is silently lost; stop is sized so a well-behaved
    // generator never gets there.
    assign w_push = pix_valid && w_accept_state && !w_full && w_in_range && !w_dup;
    assign w_pop  = mem_we && mem_ack;

`ifdef LINE_PIXEL_WRITER_DUPFILT_EN
    logic [18:0] r_last_addr;
    logic        r_last_vld;

    assign w_dup = r_last_vld && (address == r_last_addr);

    // Remember the last accepted raw address; forgotten whenever we head to IDLE.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt == c_IDLE)) begin
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
        end else if (w_push) begin
            r_last_vld  <= 1'b1;
            r_last_addr <= address;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Occupancy after this cycle's push/pop; simultaneous push+pop holds.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // FIFO storage; no reset needed since validity lives in r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_lin;
        end
    end

    // FIFO pointers, occupancy, registered backpressure and line colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stop   <= 1'b0;
            r_color  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_stop  <= (w_count_nxt >= c_STOP_LVL);
            if ((r_state == c_IDLE) && pix_valid) begin
                r_color <= color;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an empty FIFO means no write is outstanding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (line_done) begin
                    w_state_nxt = pix_valid ? c_FLUSH : c_DONE;
                end else if (pix_valid) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (line_done) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (w_empty) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // The FIFO head is the write stage: request whenever anything is stored.
    assign mem_we     = !w_empty;
    assign mem_addr   = mem_we ? r_fifo[r_rd_ptr] : '0;
    assign mem_wdata  = mem_we ? r_color : '0;
    assign stop       = r_stop;
    assign write_done = (r_state == c_DONE);
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire
